// File: rtl/layer_compositor_if.sv
// Pixel-stream bus for layer_compositor: per-layer pixels, raster timing and
// per-frame controls in, one composited pixel with matching sync out.
interface layer_compositor_if #(
  parameter int N_LAYERS = 5
);
  logic [12*N_LAYERS-1:0] layer_pix_in;
  logic [10:0]            hcount_in;
  logic [9:0]             vcount_in;
  logic                   hsync_in;
  logic                   vsync_in;
  logic                   blank_in;
  logic [N_LAYERS-1:0]    layer_en_in;
  logic                   mode_in;
  logic [2*N_LAYERS-1:0]  dim_in;
  logic [11:0]            pix_out;
  logic                   hsync_out;
  logic                   vsync_out;
  logic                   frame_start_out;

  // Streaming bus with no valid/ready: one pixel is accepted on every clk_in
  // edge, and the matching output appears a fixed number of cycles later.
  modport master (
    output layer_pix_in, hcount_in, vcount_in, hsync_in, vsync_in, blank_in,
    output layer_en_in, mode_in, dim_in,
    input  pix_out, hsync_out, vsync_out, frame_start_out
  );

  modport slave (
    input  layer_pix_in, hcount_in, vcount_in, hsync_in, vsync_in, blank_in,
    input  layer_en_in, mode_in, dim_in,
    output pix_out, hsync_out, vsync_out, frame_start_out
  );
endinterface

// File: rtl/layer_compositor.sv
// Pipelined RGB444 layer compositor: stage-1 enable/dim, a registered binary
// reduction tree (saturating add or priority), then blanking. COMPOSITOR_DIM_EN enables dim.
module layer_compositor #(
  parameter int N_LAYERS    = 5,
  parameter bit INVERT_SYNC = 1'b1
) (
  input logic               clk_in,
  input logic               rst_in,
  layer_compositor_if.slave bus
);
  localparam int LVLS   = $clog2(N_LAYERS);
  localparam int LAT    = LVLS + 2;
  localparam int LEAVES = 1 << LVLS;
  localparam int NODES  = 2 * LEAVES - 1;

  function automatic logic [11:0] combine(input logic [11:0] a, input logic [11:0] b,
                                          input logic prio);
    logic [4:0]  s;
    logic [11:0] r;
    r = '0;
    if (prio) begin
      r = (a != 12'h000) ? a : b;
    end else begin
      for (int c = 0; c < 3; c++) begin
        s = {1'b0, a[4*c +: 4]} + {1'b0, b[4*c +: 4]};
        r[4*c +: 4] = s[4] ? 4'hF : s[3:0];
      end
    end
    return r;
  endfunction

  logic                at_origin;
  logic [N_LAYERS-1:0] en_sh;
  logic                mode_sh;
  logic [N_LAYERS-1:0] en_eff;
  logic                mode_eff;

  assign at_origin = (bus.hcount_in == 11'd0) && (bus.vcount_in == 10'd0);
  // Pixel (0,0) already uses the values being sampled in that same cycle.
  assign en_eff    = at_origin ? bus.layer_en_in : en_sh;
  assign mode_eff  = at_origin ? bus.mode_in : mode_sh;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      en_sh   <= '1;
      mode_sh <= 1'b0;
    end else if (at_origin) begin
      en_sh   <= bus.layer_en_in;
      mode_sh <= bus.mode_in;
    end
  end

`ifdef COMPOSITOR_DIM_EN
  logic [2*N_LAYERS-1:0] dim_sh;
  logic [2*N_LAYERS-1:0] dim_eff;

  assign dim_eff = at_origin ? bus.dim_in : dim_sh;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)         dim_sh <= '0;
    else if (at_origin) dim_sh <= bus.dim_in;
  end
`endif

  // Leaves beyond N_LAYERS stay at zero, which is neutral in both blend modes.
  logic [11:0] leaf_d [LEAVES];
  logic [11:0] pix_k;

  always_comb begin
    pix_k = '0;
    for (int k = 0; k < LEAVES; k++) leaf_d[k] = 12'h000;
    for (int k = 0; k < N_LAYERS; k++) begin
      pix_k = bus.layer_pix_in[12*k +: 12];
`ifdef COMPOSITOR_DIM_EN
      pix_k = {pix_k[11:8] >> dim_eff[2*k +: 2], pix_k[7:4] >> dim_eff[2*k +: 2],
               pix_k[3:0] >> dim_eff[2*k +: 2]};
`endif
      leaf_d[k] = en_eff[k] ? pix_k : 12'h000;
    end
  end

  // Heap-ordered tree: node i has children 2i+1 (lower layers) and 2i+2.
  // mode_q[0] travels with the leaves, mode_q[LVLS-1] with the root's inputs.
  logic [11:0]     tree_q [NODES];
  logic [LVLS-1:0] mode_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < NODES; i++) tree_q[i] <= 12'h000;
      mode_q <= '0;
    end else begin
      for (int d = 0; d < LVLS; d++) begin
        for (int j = 0; j < (1 << d); j++) begin
          tree_q[(1 << d) - 1 + j] <= combine(tree_q[2*((1 << d) - 1 + j) + 1],
                                              tree_q[2*((1 << d) - 1 + j) + 2],
                                              mode_q[LVLS-1-d]);
        end
      end
      for (int k = 0; k < LEAVES; k++) tree_q[LEAVES-1+k] <= leaf_d[k];
      mode_q[0] <= mode_eff;
      for (int k = 1; k < LVLS; k++) mode_q[k] <= mode_q[k-1];
    end
  end

  // Side-band bits {frame_start, blank, vsync, hsync} ride alongside the tree.
  logic [3:0]  side_q [LAT-1];
  logic [11:0] pix_q;
  logic        hs_q;
  logic        vs_q;
  logic        fs_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < LAT-1; i++) side_q[i] <= 4'h0;
      pix_q <= 12'h000;
      hs_q  <= 1'b0;
      vs_q  <= 1'b0;
      fs_q  <= 1'b0;
    end else begin
      side_q[0] <= {at_origin, bus.blank_in, bus.vsync_in, bus.hsync_in};
      for (int i = 1; i < LAT-1; i++) side_q[i] <= side_q[i-1];
      pix_q <= side_q[LAT-2][2] ? 12'h000 : tree_q[0];
      hs_q  <= side_q[LAT-2][0] ^ INVERT_SYNC;
      vs_q  <= side_q[LAT-2][1] ^ INVERT_SYNC;
      fs_q  <= side_q[LAT-2][3];
    end
  end

  assign bus.pix_out         = pix_q;
  assign bus.hsync_out       = hs_q;
  assign bus.vsync_out       = vs_q;
  assign bus.frame_start_out = fs_q;
endmodule

// File: tb/tb_layer_compositor.sv
// Directed + random stimulus for layer_compositor; a behavioural model pushes
// the expected {frame_start, vsync, hsync, pix} word per pixel into a queue.
module tb_layer_compositor;
  localparam int N   = 5;
  localparam bit INV = 1'b1;
  localparam int LAT = $clog2(N) + 2;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  always #5 clk_in = ~clk_in;

  layer_compositor_if #(.N_LAYERS(N)) bus ();

  layer_compositor #(.N_LAYERS(N), .INVERT_SYNC(INV)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  logic [14:0] exp_q[$];

  logic [N-1:0]   en_s;
  logic           mode_s;
  logic [2*N-1:0] dim_s;

  function automatic logic [11:0] model_pix();
    logic [11:0] l;
    logic [11:0] acc;
    logic [4:0]  ch;
    logic        found;
    acc   = 12'h000;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      l = en_s[k] ? bus.layer_pix_in[12*k +: 12] : 12'h000;
`ifdef COMPOSITOR_DIM_EN
      l = {l[11:8] >> dim_s[2*k +: 2], l[7:4] >> dim_s[2*k +: 2], l[3:0] >> dim_s[2*k +: 2]};
`endif
      if (mode_s) begin
        if (!found && l != 12'h000) begin
          acc   = l;
          found = 1'b1;
        end
      end else begin
        for (int c = 0; c < 3; c++) begin
          ch = {1'b0, acc[4*c +: 4]} + {1'b0, l[4*c +: 4]};
          acc[4*c +: 4] = (ch > 5'd15) ? 4'hF : ch[3:0];
        end
      end
    end
    return acc;
  endfunction

  task automatic set_px(input logic [10:0] h, input logic [9:0] v,
                        input logic [12*N-1:0] px);
    bus.hcount_in    = h;
    bus.vcount_in    = v;
    bus.layer_pix_in = px;
  endtask

  task automatic step(input string tag);
    logic [14:0] e;
    logic [14:0] got;
    logic        origin;
    origin = (bus.hcount_in == 11'd0) && (bus.vcount_in == 10'd0);
    if (origin) begin
      en_s   = bus.layer_en_in;
      mode_s = bus.mode_in;
      dim_s  = bus.dim_in;
    end
    e = {origin, bus.vsync_in ^ INV, bus.hsync_in ^ INV,
         bus.blank_in ? 12'h000 : model_pix()};
    exp_q.push_back(e);
    @(posedge clk_in);
    #1;
    if (exp_q.size() == LAT) begin
      e   = exp_q.pop_front();
      got = {bus.frame_start_out, bus.vsync_out, bus.hsync_out, bus.pix_out};
      vectors++;
      assert (got === e) else begin
        miscompares++;
        $error("FAIL %s {fs,vs,hs,pix} observed=%h expected=%h", tag, got, e);
      end
    end
  endtask

  task automatic check_zero(input string tag);
    logic [14:0] got;
    got = {bus.frame_start_out, bus.vsync_out, bus.hsync_out, bus.pix_out};
    vectors++;
    assert (got === 15'h0000) else begin
      miscompares++;
      $error("FAIL %s {fs,vs,hs,pix} observed=%h expected=%h", tag, got, 15'h0000);
    end
  endtask

  // Called #1 after an edge; asserts reset mid-cycle and releases it after two edges.
  task automatic apply_reset();
    #2 rst_in = 1'b1;
    #1 check_zero("rst_async");
    @(posedge clk_in);
    #1 check_zero("rst_held");
    @(posedge clk_in);
    #1 rst_in = 1'b0;
    exp_q.delete();
    repeat (LAT-1) exp_q.push_back({1'b0, INV, INV, 12'h000});
    en_s   = '1;
    mode_s = 1'b0;
    dim_s  = '0;
  endtask

  task automatic random_steps(input int n, input string tag);
    logic [12*N-1:0] px;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < N; k++) px[12*k +: 12] = 12'($urandom_range(0, 4095));
      if ($urandom_range(0, 5) == 0) set_px(11'd0, 10'd0, px);
      else set_px(11'($urandom_range(1, 1599)), 10'($urandom_range(0, 899)), px);
      bus.hsync_in    = 1'($urandom_range(0, 1));
      bus.vsync_in    = 1'($urandom_range(0, 1));
      bus.blank_in    = ($urandom_range(0, 4) == 0);
      bus.layer_en_in = N'($urandom_range(0, (1 << N) - 1));
      bus.mode_in     = 1'($urandom_range(0, 1));
      bus.dim_in      = (2*N)'($urandom_range(0, (1 << (2*N)) - 1));
      step(tag);
    end
  endtask

  initial begin
    set_px(11'd5, 10'd5, '0);
    bus.hsync_in    = 1'b0;
    bus.vsync_in    = 1'b0;
    bus.blank_in    = 1'b0;
    bus.layer_en_in = '1;
    bus.mode_in     = 1'b0;
    bus.dim_in      = '0;
    apply_reset();

    // Additive sums and per-channel clamping.
    set_px(11'd0, 10'd0, {12'h000, 12'h000, 12'h333, 12'h222, 12'h111});
    step("add_666");
    set_px(11'd1, 10'd0, {12'h000, 12'h000, 12'h000, 12'h9A5, 12'hF80});
    step("add_clamp");
    set_px(11'd2, 10'd0, {12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF});
    step("add_all_max");
    bus.hsync_in = 1'b1;
    set_px(11'd3, 10'd0, {12'h001, 12'h010, 12'h100, 12'h000, 12'h000});
    step("add_hsync");
    bus.hsync_in = 1'b0;

    // Priority mode sampled at the origin; mid-frame enable change held off.
    bus.mode_in = 1'b1;
    bus.vsync_in = 1'b1;
    set_px(11'd0, 10'd0, {12'h000, 12'hF00, 12'h0F0, 12'h000, 12'h000});
    step("prio_first");
    bus.vsync_in = 1'b0;
    bus.mode_in  = 1'b0;
    set_px(11'd1, 10'd0, {12'h000, 12'h000, 12'h000, 12'h000, 12'h000});
    step("prio_all_zero");
    bus.layer_en_in = 5'b11011;
    set_px(11'd100, 10'd50, {12'h000, 12'hF00, 12'h0F0, 12'h000, 12'h000});
    step("en_midframe");
    set_px(11'd101, 10'd50, {12'h000, 12'hF00, 12'h0F0, 12'h000, 12'h000});
    step("en_midframe2");
    bus.mode_in = 1'b1;
    set_px(11'd0, 10'd0, {12'h000, 12'hF00, 12'h0F0, 12'h000, 12'h000});
    step("en_next_frame");
    set_px(11'd1, 10'd0, {12'h00F, 12'h000, 12'h000, 12'h000, 12'h000});
    step("prio_last_layer");

    // Attenuation of layer 0 by 2 (ignored when the dim build is off).
    bus.mode_in     = 1'b0;
    bus.layer_en_in = '1;
    bus.dim_in      = 10'b00_00_00_00_10;
    set_px(11'd0, 10'd0, {12'h000, 12'h000, 12'h000, 12'h000, 12'hFC8});
    step("dim_layer0");
    bus.dim_in = '0;

    // Blanking forces black regardless of layer content.
    bus.blank_in = 1'b1;
    set_px(11'd700, 10'd20, {12'hABC, 12'h123, 12'h456, 12'h789, 12'hFFF});
    step("blank");
    bus.blank_in = 1'b0;

    random_steps(40, "random");

    // Mid-line reset: pipeline flushed, shadows back to additive/all enabled.
    bus.mode_in = 1'b1;
    set_px(11'd0, 10'd0, {12'h000, 12'h000, 12'h000, 12'h700, 12'h800});
    step("pre_reset");
    set_px(11'd300, 10'd0, {12'h000, 12'h000, 12'h000, 12'h700, 12'h800});
    step("pre_reset2");
    apply_reset();
    for (int i = 0; i < LAT + 2; i++) begin
      bus.hsync_in = i[0];
      set_px(11'(301 + i), 10'd0, {12'h000, 12'h000, 12'h000, 12'h700, 12'h800});
      step("post_reset");
    end

    random_steps(30, "random2");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/layer_compositor.md
LAYER_COMPOSITOR -- requirements
Module: layer_compositor

Interface
REQ-001 Parameter N_LAYERS, default 5: number of 12-bit RGB444 layers, legal range 2..8.
REQ-002 Parameter INVERT_SYNC, default 1: 1 = hsync_out/vsync_out are the inverse of the inputs; 0 = they pass through unchanged.
REQ-003 clk_in  input  1  pixel clock; all state changes on its rising edge.
REQ-004 rst_in  input  1  reset; asynchronous and active-high.
REQ-005 layer_pix_in  input  12*N_LAYERS  pixel for each layer; layer k occupies bits [12k+11:12k]; layer 0 has highest priority.
REQ-006 hcount_in  input  11  horizontal pixel count, aligned with layer_pix_in.
REQ-007 vcount_in  input  10  vertical line count, aligned with layer_pix_in.
REQ-008 hsync_in, vsync_in, blank_in  input  1 each  timing signals, aligned with layer_pix_in.
REQ-009 layer_en_in  input  N_LAYERS  per-layer enable.
REQ-010 mode_in  input  1  blend mode: 0 = saturating additive, 1 = priority.
REQ-011 dim_in  input  2*N_LAYERS  per-layer attenuation shift; layer k uses bits [2k+1:2k].
REQ-012 pix_out  output  12  composited pixel.
REQ-013 hsync_out, vsync_out  output  1 each  sync signals, delayed to match pix_out.
REQ-014 frame_start_out  output  1  one-cycle pulse marking pixel (0,0) at the output.

Function
REQ-015 Shadow registers capture layer_en_in, mode_in and dim_in only in the cycle where hcount_in==0 and vcount_in==0; mid-frame changes to these inputs have no effect until the next frame.
REQ-016 Latency: pix_out, hsync_out, vsync_out and frame_start_out lag their inputs by exactly LAT = $clog2(N_LAYERS)+2 cycles; all four are delayed by the same register chain.
REQ-017 Stage 1 (registered):
- A disabled layer is forced to 12'h000.
- Otherwise each 4-bit channel of the layer is logically shifted right by its dim value.
REQ-018 Stages 2..LAT-1: a registered binary reduction tree, one tree level per stage.
- Odd operand counts at any level pass the unpaired operand through a register.
- Missing leaves are padded with 12'h000.
REQ-019 Additive mode: each R, G and B channel is summed with 5-bit intermediates and clamped to 4'hF at every tree node; a channel never wraps.
REQ-020 Priority mode: each node outputs its lower-index operand when that operand is nonzero, else the other operand; the result is the lowest-index nonzero layer, or 12'h000 if all are zero.
REQ-021 Final stage: pix_out = 12'h000 when the delayed blank is 1, else the tree result.
REQ-022 hsync_out = delayed hsync_in XOR INVERT_SYNC; vsync_out = delayed vsync_in XOR INVERT_SYNC.
REQ-023 frame_start_out is 1 exactly LAT cycles after hcount_in==0 and vcount_in==0, and 0 at all other times.
REQ-024 Shadow sampling is aligned with the pixel stream: a frame's pixel (0,0) is already processed using the newly sampled values.

Reset
REQ-025 While rst_in=1: pix_out=12'h000, hsync_out=0, vsync_out=0 and frame_start_out=0, regardless of INVERT_SYNC.
REQ-026 Reset clears all pipeline and delay registers to 0.
REQ-027 Reset sets the shadow registers to: enables all 1, mode 0, dim all 0.
REQ-028 Reset may assert mid-frame; after release, outputs are valid LAT cycles later and no stale pre-reset pixel ever appears.

Configuration
REQ-029 Macro COMPOSITOR_DIM_EN.
- Defined: attenuation operates as in REQ-017.
- Undefined: dim_in is ignored, no dim shadow register or shifter is built, and layers enter the tree unattenuated; latency is unchanged.

Verification
REQ-030 N_LAYERS=5, additive mode, all enabled, layers = 12'h111, 12'h222, 12'h333, 12'h000, 12'h000 -> pix_out = 12'h666 after 5 cycles.
REQ-031 Additive mode, layers 12'hF80 and 12'h9A5, others 0 -> pix_out = 12'hFF5 (R and G clamped, B = 5).
REQ-032 Priority mode (mode_in=1 sampled at (0,0)), layers 0 and 1 = 0, layer 2 = 12'h0F0, layer 3 = 12'hF00 -> pix_out = 12'h0F0; with layer_en_in[2]=0 in the next frame -> pix_out = 12'hF00.
REQ-033 With COMPOSITOR_DIM_EN defined, dim for layer 0 = 2'd2, layer 0 = 12'hFC8, others 0 -> pix_out = 12'h332; with the macro undefined -> pix_out = 12'hFC8.
REQ-034 Toggle layer_en_in at pixel (100,50) -> pix_out unchanged for the rest of that frame; the change takes effect from the next frame's pixel (0,0), and frame_start_out pulses 5 cycles after that pixel enters.
REQ-035 blank_in=1 with nonzero layers -> pix_out = 12'h000; assert rst_in mid-line -> all outputs immediately 0, and after release outputs resume exactly 5 cycles later with correct sync polarity.
